instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 20 ++
 rtl/instr_fetch_unit_if.sv | 30 +++
 rtl/instr_fetch_unit_fetch_fifo.sv | 59 +++++
 rtl/instr_fetch_unit.sv | 99 +++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
// The package also holds the default depths and the word-address helper.
package instr_fetch_unit_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] INSTR_NOP = 32'h0000_0000;
    localparam int MAX_OUTST_DEF = 2;
    localparam int BUF_DEPTH_DEF = 2;

    // One instruction buffer entry: fetch address plus the returned word.
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } buf_entry_t;

    function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the instruction-memory request/response signals and the decode handshake.
// The master modport is the fetch-unit side; the slave modport is the memory/decode side.
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [WORD_W-1:0] imem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] instr_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small synchronous circular FIFO with a synchronous clear and an occupancy count.
// The head is read combinationally so data is visible in the same cycle count goes non-zero.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= din;
    end

    // Callers guarantee space/data through credit accounting; these catch violations.
    always_ff @(posedge clk) begin
        if (!reset && !clear) begin
            assert (!(push && count_reg == CNT_W'(DEPTH)));
            assert (!(pop && count_reg == '0));
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word reads at pc under a credit rule, tags responses with
// their PC, buffers them for decode, and drops in-flight responses after a flush.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int MAX_OUTST = MAX_OUTST_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] pc,
    output logic              pc_ld,
    input  logic              flush,
    output logic              misalign,
    instr_fetch_unit_if.master bus
);

    localparam int OUT_W = $clog2(MAX_OUTST + 1);
    localparam int BUF_W = $clog2(BUF_DEPTH + 1);

    logic [OUT_W-1:0]  outst;
    logic [OUT_W-1:0]  discard_reg;
    logic [OUT_W-1:0]  discard_next;
    logic [BUF_W-1:0]  fifo_count;
    logic [WORD_W-1:0] tag_pc;
    logic [31:0]       used_slots;
    logic              can_issue;
    logic              rsp;
    logic              keep;
    logic              head_valid;
    logic              deq;
    buf_entry_t        head;
    buf_entry_t        wr_entry;

    // A new request is allowed only if every live request already has a buffer slot reserved.
    always_comb begin
        used_slots = 32'(fifo_count) + 32'(outst) - 32'(discard_reg);
        can_issue  = !reset && !flush
                     && (32'(outst) < 32'(MAX_OUTST))
                     && (used_slots < 32'(BUF_DEPTH));
    end

    assign bus.imem_req  = can_issue && (pc[1:0] == 2'b00);
    assign misalign      = can_issue && (pc[1:0] != 2'b00);
    assign bus.imem_addr = word_addr(pc);
    assign pc_ld         = bus.imem_req & bus.imem_gnt;

    assign rsp        = bus.imem_rvalid & ~reset;
    assign keep       = rsp && (discard_reg == '0);
    assign head_valid = (fifo_count != '0) && !reset;
    assign deq        = head_valid & bus.instr_ready;
    assign wr_entry   = '{pc: tag_pc, instr: bus.imem_rdata};

    // The tag queue occupancy doubles as the outstanding-request count.
    fetch_fifo #(.WIDTH(WORD_W), .DEPTH(MAX_OUTST)) u_tag_q (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .push  (pc_ld),
        .pop   (rsp),
        .din   (pc),
        .dout  (tag_pc),
        .count (outst)
    );

    fetch_fifo #(.WIDTH($bits(buf_entry_t)), .DEPTH(BUF_DEPTH)) u_buf (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (keep),
        .pop   (deq),
        .din   (wr_entry),
        .dout  (head),
        .count (fifo_count)
    );

    // On flush every request still in flight after this cycle's response becomes stale.
    always_comb begin
        discard_next = discard_reg;
        if (flush) begin
            discard_next = outst - OUT_W'(rsp);
        end else if (rsp && (discard_reg != '0)) begin
            discard_next = discard_reg - OUT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            discard_reg <= '0;
        end else begin
            discard_reg <= discard_next;
        end
    end

    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_valid ? head.instr : INSTR_NOP;
    assign bus.instr_pc    = head_valid ? head.pc : '0;

endmodule
